// File: rtl/count_sequence_checker.sv
// Receive-side monitor for the wrapping index stream of the sequence counter.
// Predicts the next index, acquires lock, flags slips, counts errors and laps.
module count_sequence_checker #(
    parameter int WIDTH      = 6,
    parameter int WRAP_HI    = 61,
    parameter int WRAP_LO    = 1,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int CNT_W      = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Value,
    input  logic             Clear,
    output logic             Locked,
    output logic             Mismatch,
    output logic             WrapPulse,
    output logic [WIDTH-1:0] Expected,
    output logic [CNT_W-1:0] ErrCount,
    output logic [CNT_W-1:0] LapCount,
    output logic             Sticky
);

    localparam int MR_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [WIDTH-1:0] HI     = WIDTH'(WRAP_HI);
    localparam logic [WIDTH-1:0] LO     = WIDTH'(WRAP_LO);
    localparam logic [MR_W-1:0]  LOCK_N = MR_W'(LOCK_COUNT);
    localparam logic [MS_W-1:0]  ERR_N  = MS_W'(ERR_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [MR_W-1:0]  mr_q, mr_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             prev_hi_q, prev_hi_d;
    logic             locked_q, locked_d;
    logic             mism_q, err;
    logic             wrap_q, wrap;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [CNT_W-1:0] lapc_q, lapc_d;
    logic             sticky_q, sticky_d;
    logic             match;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
        return (v == HI) ? LO : v + 1'b1;
    endfunction

    assign match = (Value == exp_q);

    // Next-state, prediction, run counters and error/lap bookkeeping
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        mr_d      = mr_q;
        ms_d      = ms_q;
        prev_hi_d = prev_hi_q;
        err       = 1'b0;
        wrap      = 1'b0;
        if (Valid) begin
            prev_hi_d = (Value == HI);
            if (Value > HI) begin
                err     = 1'b1;
                state_d = HUNT;
                exp_d   = '0;
                mr_d    = '0;
                ms_d    = '0;
            end else begin
                exp_d = nxt(Value);
                unique case (state_q)
                    HUNT: begin
                        mr_d    = MR_W'(1);
                        state_d = SYNC;
                    end
                    SYNC: begin
                        if (match) begin
                            mr_d = mr_q + 1'b1;
                            if (mr_q + 1'b1 == LOCK_N) begin
                                state_d = LOCKED;
                                ms_d    = '0;
                            end
                        end else begin
                            mr_d = MR_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            ms_d = '0;
                            wrap = prev_hi_q && (Value == LO);
                        end else begin
                            err  = 1'b1;
                            ms_d = MS_W'(1);
                            if (ERR_N == MS_W'(1)) begin
                                state_d = HUNT;
                                mr_d    = '0;
                                ms_d    = '0;
                            end else begin
                                state_d = SLIP;
                            end
                        end
                    end
                    SLIP: begin
                        if (match) begin
                            state_d = LOCKED;
                            ms_d    = '0;
                            wrap    = prev_hi_q && (Value == LO);
                        end else begin
                            err  = 1'b1;
                            ms_d = ms_q + 1'b1;
                            if (ms_q + 1'b1 == ERR_N) begin
                                state_d = HUNT;
                                mr_d    = '0;
                                ms_d    = '0;
                            end
                        end
                    end
                endcase
            end
        end
        locked_d = (state_d == LOCKED) || (state_d == SLIP);

        errc_d = Clear ? '0 : errc_q;
        if (err) begin
            if (Clear)
                errc_d = CNT_W'(1);
            else if (errc_q != '1)
                errc_d = errc_q + 1'b1;
        end
        sticky_d = err ? 1'b1 : (Clear ? 1'b0 : sticky_q);
        lapc_d   = Clear ? '0 : lapc_q;
        if (wrap)
            lapc_d = Clear ? CNT_W'(1) : lapc_q + 1'b1;
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            mr_q      <= '0;
            ms_q      <= '0;
            prev_hi_q <= 1'b0;
            locked_q  <= 1'b0;
            mism_q    <= 1'b0;
            wrap_q    <= 1'b0;
            errc_q    <= '0;
            lapc_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            mr_q      <= mr_d;
            ms_q      <= ms_d;
            prev_hi_q <= prev_hi_d;
            locked_q  <= locked_d;
            mism_q    <= err;
            wrap_q    <= wrap;
            errc_q    <= errc_d;
            lapc_q    <= lapc_d;
            sticky_q  <= sticky_d;
        end
    end

    assign Locked    = locked_q;
    assign Mismatch  = mism_q;
    assign WrapPulse = wrap_q;
    assign Expected  = exp_q;
    assign ErrCount  = errc_q;
    assign LapCount  = lapc_q;
    assign Sticky    = sticky_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker.
// Hand-computed expectations for lock, wrap, slip, range and clear behaviour.
module tb_count_sequence_checker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic [5:0] Value = '0;
    logic       Clear = 1'b0;
    logic       Locked, Mismatch, WrapPulse, Sticky;
    logic [5:0] Expected;
    logic [7:0] ErrCount, LapCount;

    int total = 0;
    int bad   = 0;

    count_sequence_checker dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Valid    (Valid),
        .Value    (Value),
        .Clear    (Clear),
        .Locked   (Locked),
        .Mismatch (Mismatch),
        .WrapPulse(WrapPulse),
        .Expected (Expected),
        .ErrCount (ErrCount),
        .LapCount (LapCount),
        .Sticky   (Sticky)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [5:0] v,
                        input logic clr);
        @(negedge Clk);
        Valid = vld;
        Value = v;
        Clear = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        repeat (2) begin
            @(negedge Clk);
            Reset = 1'b0;
            Valid = 1'b0;
            Clear = 1'b0;
        end
        @(posedge Clk);
        #1;
        chk({tag, ".locked"}, 32'(Locked), 0);
        chk({tag, ".mism"}, 32'(Mismatch), 0);
        chk({tag, ".wrap"}, 32'(WrapPulse), 0);
        chk({tag, ".exp"}, 32'(Expected), 0);
        chk({tag, ".errc"}, 32'(ErrCount), 0);
        chk({tag, ".lapc"}, 32'(LapCount), 0);
        chk({tag, ".sticky"}, 32'(Sticky), 0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic lock_from(input logic [5:0] s);
        step(1, s, 0);
        step(1, s + 6'd1, 0);
        step(1, s + 6'd2, 0);
        chk("lock.pre", 32'(Locked), 0);
        step(1, s + 6'd3, 0);
        chk("lock.post", 32'(Locked), 1);
    endtask

    initial begin
        // 1: reset and first lock
        do_reset("rst0");
        lock_from(6'd0);
        chk("t1.exp", 32'(Expected), 4);
        chk("t1.errc", 32'(ErrCount), 0);

        // 2: wrap 60,61,1,2
        do_reset("rst2");
        lock_from(6'd56);
        chk("t2.exp", 32'(Expected), 60);
        step(1, 6'd60, 0);
        chk("t2.w60", 32'(WrapPulse), 0);
        step(1, 6'd61, 0);
        chk("t2.exp61", 32'(Expected), 1);
        step(1, 6'd1, 0);
        chk("t2.wrap", 32'(WrapPulse), 1);
        chk("t2.lap", 32'(LapCount), 1);
        chk("t2.mism", 32'(Mismatch), 0);
        chk("t2.exp1", 32'(Expected), 2);
        step(1, 6'd2, 0);
        chk("t2.wrap2", 32'(WrapPulse), 0);
        chk("t2.lap2", 32'(LapCount), 1);

        // 3: single slip 10,11,20,21
        do_reset("rst3");
        lock_from(6'd6);
        step(1, 6'd10, 0);
        step(1, 6'd11, 0);
        chk("t3.mism0", 32'(Mismatch), 0);
        step(1, 6'd20, 0);
        chk("t3.mism", 32'(Mismatch), 1);
        chk("t3.errc", 32'(ErrCount), 1);
        chk("t3.sticky", 32'(Sticky), 1);
        chk("t3.locked", 32'(Locked), 1);
        chk("t3.exp", 32'(Expected), 21);
        step(1, 6'd21, 0);
        chk("t3.mism2", 32'(Mismatch), 0);
        chk("t3.locked2", 32'(Locked), 1);
        chk("t3.errc2", 32'(ErrCount), 1);

        // 4: lose lock 10,30,50,5 then relock 6..9
        do_reset("rst4");
        lock_from(6'd6);
        step(1, 6'd10, 0);
        step(1, 6'd30, 0);
        chk("t4.lk30", 32'(Locked), 1);
        step(1, 6'd50, 0);
        chk("t4.lk50", 32'(Locked), 1);
        chk("t4.errc50", 32'(ErrCount), 2);
        step(1, 6'd5, 0);
        chk("t4.errc", 32'(ErrCount), 3);
        chk("t4.mism", 32'(Mismatch), 1);
        chk("t4.unlock", 32'(Locked), 0);
        chk("t4.exp", 32'(Expected), 6);
        lock_from(6'd6);
        chk("t4.exp2", 32'(Expected), 10);
        chk("t4.errc2", 32'(ErrCount), 3);

        // 5: out-of-range in SYNC, then saturation
        do_reset("rst5");
        step(1, 6'd5, 0);
        step(1, 6'd6, 0);
        step(1, 6'd62, 0);
        chk("t5.mism", 32'(Mismatch), 1);
        chk("t5.errc", 32'(ErrCount), 1);
        chk("t5.sticky", 32'(Sticky), 1);
        chk("t5.locked", 32'(Locked), 0);
        chk("t5.exp", 32'(Expected), 0);
        for (int i = 0; i < 254; i++)
            step(1, 6'd62, 0);
        chk("t5.errc255", 32'(ErrCount), 255);
        step(1, 6'd63, 0);
        chk("t5.sat", 32'(ErrCount), 255);
        chk("t5.mism63", 32'(Mismatch), 1);

        // 6: idle hold, clear interactions, reset while locked
        do_reset("rst6");
        lock_from(6'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 6'd33, 0);
            chk("t6.hold.lk", 32'(Locked), 1);
            chk("t6.hold.exp", 32'(Expected), 4);
            chk("t6.hold.mism", 32'(Mismatch), 0);
        end
        step(1, 6'd4, 0);
        step(1, 6'd9, 0);
        chk("t6.errc1", 32'(ErrCount), 1);
        step(1, 6'd10, 0);
        step(1, 6'd20, 1);
        chk("t6.clr.errc", 32'(ErrCount), 1);
        chk("t6.clr.sticky", 32'(Sticky), 1);
        chk("t6.clr.mism", 32'(Mismatch), 1);
        step(0, 6'd0, 1);
        chk("t6.clr2.errc", 32'(ErrCount), 0);
        chk("t6.clr2.sticky", 32'(Sticky), 0);
        chk("t6.clr2.lk", 32'(Locked), 1);
        chk("t6.clr2.exp", 32'(Expected), 21);
        do_reset("rst7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
